cart_bus_seq: RTL and testbench
===============================

CART_BUS_SEQ -- requirements
Module: cart_bus_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, cycles the address is stable before the strobe (legal range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 8, cycles the access strobe is held (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, cycles the address and data are held after the strobe (legal range 1..15).
REQ-004 SHALL have port clk  input  1  the single system clock; all state is clocked on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  1  CPU-side request present.
REQ-007 SHALL have port req_ready  output  1  the sequencer accepts a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  16  request address.
REQ-010 SHALL have port req_wdata  input  8  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  8  read data of the most recent completed read.
REQ-013 SHALL have port busy  output  1  an access is in progress (state other than IDLE).
REQ-014 SHALL have port bus_addr  output  16  address to the cartridge pin interface.
REQ-015 SHALL have port bus_write_enable  output  1  active-high write strobe to the cartridge pin interface.
REQ-016 SHALL have port bus_write_value  output  8  write data to the cartridge pin interface.
REQ-017 SHALL have port bus_read_value  input  8  data returned from the cartridge pins.

Function
REQ-018 SHALL implement the FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE; each non-IDLE state lasts exactly its parameter's number of cycles.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a rising edge where req_valid & req_ready, and the FSM enters SETUP.
REQ-020 SHALL ignore req_valid when req_ready = 0; the requester holds its request, and nothing is queued.
REQ-021 SHALL capture req_addr, req_write and req_wdata at acceptance into registers that drive bus_addr and bus_write_value from the first SETUP cycle through the last HOLD cycle.
REQ-022 SHALL assert bus_write_enable only during STROBE cycles of a write access; it is 0 in IDLE, SETUP, HOLD and in all read states.
REQ-023 SHALL sample bus_read_value into rsp_rdata on the rising edge that ends the last STROBE cycle of a read access; writes leave rsp_rdata unchanged.
REQ-024 SHALL pulse rsp_valid high for exactly one cycle, the first IDLE cycle after HOLD, giving latency acceptance-edge to rsp_valid = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
REQ-025 SHALL allow back-to-back accesses: a request accepted in the same cycle rsp_valid is high starts the next SETUP on the following cycle.
REQ-026 SHALL keep bus_addr and bus_write_value at their last values while in IDLE; they are not cleared between accesses.
REQ-027 SHALL use one 4-bit down-counter, loaded with (parameter-1) on each state entry and advancing state at zero; it never wraps.
REQ-028 SHALL drive busy = 1 in SETUP, STROBE and HOLD and 0 in IDLE.

Reset
REQ-029 SHALL, while n_rst = 0, force state IDLE, counter 0, bus_addr 16'h0000, bus_write_value 8'h00, bus_write_enable 0, rsp_valid 0, rsp_rdata 8'h00 and busy 0; req_ready is then 1.
REQ-030 SHALL, when reset asserts mid-access, abandon the access immediately with no rsp_valid, and deassert bus_write_enable asynchronously.
REQ-031 SHALL accept a new request on the first rising edge after n_rst deasserts.

Verification
REQ-032 Read with defaults: accept addr 16'h0147 with bus_read_value = 8'h03 during STROBE -> rsp_valid exactly 12 cycles after acceptance and rsp_rdata = 8'h03.
REQ-033 Write with defaults: addr 16'h2000, data 8'h05 -> bus_write_enable high for exactly 8 cycles, bus_addr = 16'h2000 for all 11 busy cycles, and rsp_rdata unchanged.
REQ-034 Back-to-back: req_valid held high with two reads -> second SETUP starts the cycle after the first rsp_valid, with no idle gap beyond one cycle.
REQ-035 Reset during STROBE of a write -> bus_write_enable drops without waiting for a clock edge, no rsp_valid occurs, and all outputs match REQ-029.
REQ-036 Parameters SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 -> latency 4 cycles, and read data is sampled at the single STROBE edge.
REQ-037 req_valid pulsed during busy -> the request is ignored and no extra rsp_valid is produced.

Source files
------------

// File: rtl/cart_bus_seq.sv
// cart_bus_seq
//   Sequences one CPU read or write onto a cartridge pin interface. Each
//   access runs IDLE -> SETUP -> STROBE -> HOLD -> IDLE. The address and
//   write data are held stable for the whole access. The write strobe is
//   only raised during STROBE of a write. Read data is captured as STROBE
//   ends. A one-cycle completion pulse is issued on returning to IDLE.
//
// Parameters
//   SETUP_CYC   cycles the address is stable before the strobe (1..15)
//   STROBE_CYC  cycles the strobe is held (1..15)
//   HOLD_CYC    cycles address/data are held after the strobe (1..15)
//
// Ports
//   clk               system clock, rising edge
//   n_rst             asynchronous active-low reset
//   req_valid         CPU request present
//   req_ready         sequencer can accept a request (IDLE only)
//   req_write         1 = write, 0 = read
//   req_addr          request address
//   req_wdata         write data
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         data of the most recent completed read
//   busy              access in progress
//   bus_addr          address to the cartridge pins
//   bus_write_enable  active-high write strobe to the cartridge pins
//   bus_write_value   write data to the cartridge pins
//   bus_read_value    data returned from the cartridge pins
module cart_bus_seq #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic        bus_write_enable,
  output logic [7:0]  bus_write_value,
  input  logic [7:0]  bus_read_value
);

  // The counter is loaded with (cycles - 1) on state entry, so a state
  // lasts exactly its parameter's number of cycles when it exits at zero.
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       is_write;
  logic       cnt_done;

  assign cnt_done = (cnt == 4'd0);

  // Every output is a register. The async reset therefore drops the write
  // strobe at once and cancels any pending completion pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      is_write         <= 1'b0;
      req_ready        <= 1'b1;
      busy             <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= 8'h00;
      bus_addr         <= 16'h0000;
      bus_write_value  <= 8'h00;
      bus_write_enable <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // bus_addr / bus_write_value keep their last values until the next acceptance
          if (req_valid) begin
            state           <= SETUP;
            cnt             <= SETUP_LOAD;
            is_write        <= req_write;
            bus_addr        <= req_addr;
            bus_write_value <= req_wdata;
            req_ready       <= 1'b0;
            busy            <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            state            <= STROBE;
            cnt              <= STROBE_LOAD;
            bus_write_enable <= is_write;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          // read data is taken on the edge that closes the last strobe cycle
          if (cnt_done) begin
            state            <= HOLD;
            cnt              <= HOLD_LOAD;
            bus_write_enable <= 1'b0;
            if (!is_write) begin
              rsp_rdata <= bus_read_value;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          // ready returns together with rsp_valid so back-to-back requests need no gap
          if (cnt_done) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_seq.sv
// tb_cart_bus_seq
//   Drives two sequencers from one shared request stream: one with default
//   timing (2/8/1) and one with minimum timing (1/1/1). Each is compared every
//   cycle against a transaction-level model. The model records the cycle in
//   which an access starts and derives every output from offsets into that
//   access.
module tb_cart_bus_seq;

  logic        clk;
  logic        n_rst;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  bus_read_value;

  logic        ready0, rsp_valid0, busy0, we0;
  logic [7:0]  rdata0, wval0;
  logic [15:0] addr0;
  logic        ready1, rsp_valid1, busy1, we1;
  logic [7:0]  rdata1, wval1;
  logic [15:0] addr1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cart_bus_seq dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rdata0), .busy(busy0),
    .bus_addr(addr0), .bus_write_enable(we0), .bus_write_value(wval0),
    .bus_read_value(bus_read_value)
  );

  cart_bus_seq #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rdata1), .busy(busy1),
    .bus_addr(addr1), .bus_write_enable(we1), .bus_write_value(wval1),
    .bus_read_value(bus_read_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] rdv);
    @(posedge clk);
    #1;
    req_valid      = valid;
    req_write      = write;
    req_addr       = addr;
    req_wdata      = wdata;
    bus_read_value = rdv;
  endtask

  // Transaction-level reference model, one slot per instance
  int          m_s[2] = '{2, 1};
  int          m_t[2] = '{8, 1};
  int          m_h[2] = '{1, 1};
  bit          m_act[2];
  int          m_start[2];
  bit          m_write[2];
  logic [15:0] m_addr[2];
  logic [7:0]  m_wdata[2];
  logic [7:0]  m_rdata[2];

  always @(negedge clk) begin
    logic        o_ready, o_rsp, o_busy, o_we;
    logic [7:0]  o_rdata, o_wval;
    logic [15:0] o_addr;
    bit          in_acc;
    int          off;
    int          len;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_ready = ready0; o_rsp = rsp_valid0; o_busy = busy0; o_we = we0;
        o_rdata = rdata0; o_wval = wval0; o_addr = addr0;
      end else begin
        o_ready = ready1; o_rsp = rsp_valid1; o_busy = busy1; o_we = we1;
        o_rdata = rdata1; o_wval = wval1; o_addr = addr1;
      end
      if (!n_rst) begin
        m_act[d]   = 1'b0;
        m_write[d] = 1'b0;
        m_addr[d]  = 16'h0000;
        m_wdata[d] = 8'h00;
        m_rdata[d] = 8'h00;
      end
      len    = m_s[d] + m_t[d] + m_h[d];
      off    = cyc - m_start[d];
      in_acc = m_act[d] && off >= 0 && off < len;
      checkOutput($sformatf("d%0d_ready", d), 32'(o_ready), 32'(!in_acc));
      checkOutput($sformatf("d%0d_busy", d), 32'(o_busy), 32'(in_acc));
      checkOutput($sformatf("d%0d_we", d), 32'(o_we),
                  32'(in_acc && m_write[d] && off >= m_s[d] && off < m_s[d] + m_t[d]));
      checkOutput($sformatf("d%0d_rsp_valid", d), 32'(o_rsp), 32'(m_act[d] && off == len));
      checkOutput($sformatf("d%0d_bus_addr", d), 32'(o_addr), 32'(m_addr[d]));
      checkOutput($sformatf("d%0d_bus_wval", d), 32'(o_wval), 32'(m_wdata[d]));
      checkOutput($sformatf("d%0d_rsp_rdata", d), 32'(o_rdata), 32'(m_rdata[d]));
      // last strobe cycle of a read: data becomes visible from the next cycle
      if (in_acc && !m_write[d] && off == m_s[d] + m_t[d] - 1)
        m_rdata[d] = bus_read_value;
      if (m_act[d] && off == len)
        m_act[d] = 1'b0;
      if (n_rst && !in_acc && req_valid) begin
        m_act[d]   = 1'b1;
        m_start[d] = cyc + 1;
        m_write[d] = req_write;
        m_addr[d]  = req_addr;
        m_wdata[d] = req_wdata;
      end
    end
  end

  initial begin
    int lat0, lat1, we_cnt, busy_cnt, addr_ok;
    n_rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 16'h0; req_wdata = 8'h0; bus_read_value = 8'h0;
    repeat (3) @(posedge clk);

    // read 0x0147 issued on the very first edge after reset release
    #1;
    n_rst = 1'b1; req_valid = 1'b1; req_write = 1'b0;
    req_addr = 16'h0147; bus_read_value = 8'h03;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(ready0), 32'd1);
    lat0 = 0; lat1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      req_valid = (i == 3);
      @(negedge clk);
      if (rsp_valid1 && lat1 == 0) lat1 = i;
      if (rsp_valid0) begin
        lat0 = i;
        break;
      end
    end
    checkOutput("read_latency_default", 32'(lat0), 32'd12);
    checkOutput("read_data_default", 32'(rdata0), 32'h03);
    checkOutput("read_latency_fast", 32'(lat1), 32'd4);
    checkOutput("read_data_fast", 32'(rdata1), 32'h03);

    // write 0x05 to 0x2000
    applyStimulus(1'b1, 1'b1, 16'h2000, 8'h05, 8'hEE);
    @(negedge clk);
    checkOutput("write_accept_ready", 32'(ready0), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 8'hEE);
    we_cnt = 0; busy_cnt = 0; addr_ok = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (we0) we_cnt++;
      if (busy0) busy_cnt++;
      if (busy0 && addr0 == 16'h2000) addr_ok++;
    end
    checkOutput("write_we_cycles", 32'(we_cnt), 32'd8);
    checkOutput("write_busy_cycles", 32'(busy_cnt), 32'd11);
    checkOutput("write_addr_cycles", 32'(addr_ok), 32'd11);
    checkOutput("write_keeps_rdata", 32'(rdata0), 32'h03);

    // reset in the middle of a write strobe
    applyStimulus(1'b1, 1'b1, 16'h3456, 8'hA5, 8'h11);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 8'h11);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (we0) break;
    end
    checkOutput("we_before_reset", 32'(we0), 32'd1);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    checkOutput("rst_we_async", 32'(we0), 32'd0);
    checkOutput("rst_busy", 32'(busy0), 32'd0);
    checkOutput("rst_ready", 32'(ready0), 32'd1);
    checkOutput("rst_addr", 32'(addr0), 32'h0);
    checkOutput("rst_wval", 32'(wval0), 32'h0);
    checkOutput("rst_rdata", 32'(rdata0), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;

    // back-to-back reads with req_valid held high
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom));

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 3) != 0, 1'($urandom), 16'($urandom),
                    8'($urandom), 8'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
